// File: rtl/receiver.sv
// receiver: 8N1 serial receiver with valid/ack handshake, framing-error and overrun flags
// Ports: clk          - single clock, rising edge
//        rst          - asynchronous reset, active low
//        rxd          - serial input, idle high, treated as asynchronous
//        ack          - consumer accepts data in any cycle with valid high
//        data         - last received byte
//        valid        - byte available, held until acknowledged
//        frame_error  - one-cycle pulse when the stop bit is sampled low
//        overrun      - one-cycle pulse when a byte replaces an unacknowledged one
module receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       ack,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_error,
   output logic       overrun
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, RECOVER = 3'd4;
   logic [2:0] state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d, data_q, data_d;
   logic s1_q, s1_d, s2_q, s2_d;
   logic valid_q, valid_d, frame_error_q, frame_error_d, overrun_q, overrun_d;
   logic bit_end, half_end;
   always_comb begin
      s1_d = rxd;
      s2_d = s1_q;
      bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
      half_end = cnt_q == CW'(HALF - 1);
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      bit_d = bit_q;
      shift_d = shift_q;
      data_d = data_q;
      valid_d = valid_q & ~ack;
      frame_error_d = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: if (!s2_q) begin
            state_d = START;
            cnt_d = '0;
         end
         // a start bit that is no longer low at mid-bit is a glitch
         START: if (half_end) begin
            state_d = s2_q ? IDLE : DATA;
            cnt_d = '0;
            bit_d = '0;
         end
         // samples land mid-bit because the count restarted at the start-bit centre
         DATA: if (bit_end) begin
            cnt_d = '0;
            shift_d = {s2_q, shift_q[7:1]};
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = STOP;
         end
         STOP: if (bit_end) begin
            if (s2_q) begin
               data_d = shift_q;
               valid_d = 1'b1;
               overrun_d = valid_q & ~ack;
               state_d = IDLE;
            end else begin
               frame_error_d = 1'b1;
               state_d = RECOVER;
            end
         end
         // a low line after a bad stop bit must not be taken as a new start bit
         RECOVER: if (s2_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         data_q <= data_d;
         valid_q <= valid_d;
         frame_error_q <= frame_error_d;
         overrun_q <= overrun_d;
      end
   end
   assign data = data_q;
   assign valid = valid_q;
   assign frame_error = frame_error_q;
   assign overrun = overrun_q;
endmodule
